ps2_keyboard_rx: RTL and testbench

//   Parametrised PS/2 keyboard receiver; successor to the ad-hoc clock/data filter plus serial2parallel path.

---
 rtl/ps2_keyboard_rx.sv | 249 ++++++++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//   PS/2 keyboard receiver. The raw PS2_CLK/PS2_DATA lines are synchronised
//   and glitch-filtered. Each falling edge of the filtered clock strobes one
//   bit into an 11-bit frame deframer (start, 8 data bits LSB-first, odd
//   parity, stop). E0/F0 prefix bytes are folded into flags. Complete
//   keycodes are buffered in a first-word fall-through FIFO.
//
//   Handshake: oValid high means oCode/oBreak/oExtended describe the head
//   entry. iPop high while oValid is high consumes that entry at the next
//   clock edge. iPop while oValid is low is ignored.
//
// Ports
//   Clock, Reset    system clock, synchronous active-high reset
//   PS2_CLK         raw keyboard clock (asynchronous)
//   PS2_DATA        raw keyboard data (asynchronous)
//   iPop            consume the head entry
//   iClearErr       clear the sticky error flags
//   oValid          FIFO not empty
//   oCode           head scancode
//   oBreak          head entry was preceded by F0
//   oExtended       head entry was preceded by E0
//   oFull           FIFO holds FIFO_DEPTH entries
//   oOverflow       sticky: an entry was dropped because the FIFO was full
//   oParityErr      sticky: a frame with even parity was received
//   oFrameErr       sticky: stop bit was 0, or the frame watchdog expired
module ps2_keyboard_rx #(
    parameter int FILTER_LEN    = 8,
    parameter int FIFO_DEPTH    = 16,
    parameter int TIMEOUT_CYC   = 50000,
    parameter bit DECODE_PREFIX = 1'b1
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       iPop,
    input  logic       iClearErr,
    output logic       oValid,
    output logic [7:0] oCode,
    output logic       oBreak,
    output logic       oExtended,
    output logic       oFull,
    output logic       oOverflow,
    output logic       oParityErr,
    output logic       oFrameErr
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // ---------------- input synchroniser and glitch filter ----------------
    logic [1:0]            clk_sync, data_sync;
    logic [FILTER_LEN-1:0] clk_sh, data_sh, clk_sh_next, data_sh_next;
    logic                  filt_clk, filt_data, filt_clk_d;
    logic                  strobe;

    assign clk_sh_next  = {clk_sh[FILTER_LEN-2:0], clk_sync[1]};
    assign data_sh_next = {data_sh[FILTER_LEN-2:0], data_sync[1]};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            clk_sh     <= '1;
            data_sh    <= '1;
            filt_clk   <= 1'b1;
            filt_data  <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], PS2_CLK};
            data_sync  <= {data_sync[0], PS2_DATA};
            clk_sh     <= clk_sh_next;
            data_sh    <= data_sh_next;
            // Filtered value moves only when every sample agrees.
            if (&clk_sh_next)       filt_clk <= 1'b1;
            else if (~|clk_sh_next) filt_clk <= 1'b0;
            if (&data_sh_next)       filt_data <= 1'b1;
            else if (~|data_sh_next) filt_data <= 1'b0;
            filt_clk_d <= filt_clk;
        end
    end

    // Data and clock share an identical pipeline, so filt_data is aligned
    // with the clock edge that produces the strobe.
    assign strobe = filt_clk_d & ~filt_clk;

    // ---------------- frame deframer FSM ----------------
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          state, state_next;
    logic [2:0]      bit_cnt, bit_cnt_next;
    logic [7:0]      shift, shift_next;
    logic            par_bit, par_bit_next;
    logic [TW-1:0]   wd_cnt, wd_cnt_next;
    logic            byte_ok, par_bad, stop_bad, timeout;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            par_bit <= par_bit_next;
            wd_cnt  <= wd_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        par_bit_next = par_bit;
        wd_cnt_next  = wd_cnt;
        byte_ok      = 1'b0;
        par_bad      = 1'b0;
        stop_bad     = 1'b0;
        timeout      = 1'b0;

        // Watchdog: idle in S_IDLE, reloaded by every strobe.
        if (state == S_IDLE || strobe) begin
            wd_cnt_next = '0;
        end else if (wd_cnt == TW'(TIMEOUT_CYC - 1)) begin
            timeout     = 1'b1;
            wd_cnt_next = '0;
            state_next  = S_IDLE;
        end else begin
            wd_cnt_next = wd_cnt + TW'(1);
        end

        if (strobe) begin
            unique case (state)
                S_IDLE: begin
                    if (!filt_data) begin
                        state_next   = S_DATA;
                        bit_cnt_next = '0;
                    end
                end
                S_DATA: begin
                    shift_next   = {filt_data, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = S_PARITY;
                end
                S_PARITY: begin
                    par_bit_next = filt_data;
                    state_next   = S_STOP;
                end
                S_STOP: begin
                    stop_bad   = ~filt_data;
                    par_bad    = ~(^{shift, par_bit});
                    byte_ok    = filt_data & (^{shift, par_bit});
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // ---------------- prefix decode ----------------
    logic       acc_valid;
    logic [7:0] acc_byte;
    logic       ext_pend, brk_pend;
    logic       push;
    logic [9:0] push_data;
    logic       is_e0, is_f0;

    assign is_e0 = DECODE_PREFIX && (acc_byte == 8'hE0);
    assign is_f0 = DECODE_PREFIX && (acc_byte == 8'hF0);
    assign push  = acc_valid && !is_e0 && !is_f0;
    assign push_data = DECODE_PREFIX ? {ext_pend, brk_pend, acc_byte}
                                     : {2'b00, acc_byte};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc_valid <= 1'b0;
            acc_byte  <= '0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
        end else begin
            acc_valid <= byte_ok;
            if (byte_ok) acc_byte <= shift;
            if (acc_valid) begin
                if (is_e0)      ext_pend <= 1'b1;
                else if (is_f0) brk_pend <= 1'b1;
                else begin
                    // Cleared even when the FIFO drops the entry.
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
        end
    end

    // ---------------- FWFT FIFO ----------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, do_pop, do_push, ovf_set;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = iPop && !empty;
    assign do_push = push && (!full || do_pop);
    assign ovf_set = push && full && !do_pop;

    always_ff @(posedge Clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // ---------------- sticky error flags (set beats clear) ----------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oOverflow  <= 1'b0;
            oParityErr <= 1'b0;
            oFrameErr  <= 1'b0;
        end else begin
            if (ovf_set)        oOverflow <= 1'b1;
            else if (iClearErr) oOverflow <= 1'b0;
            if (par_bad)        oParityErr <= 1'b1;
            else if (iClearErr) oParityErr <= 1'b0;
            if (stop_bad || timeout) oFrameErr <= 1'b1;
            else if (iClearErr)      oFrameErr <= 1'b0;
        end
    end

    // Head fields are forced to 0 while empty so nothing stale is visible.
    assign oValid    = !empty;
    assign oFull     = full;
    assign oCode     = empty ? 8'h00 : mem[rd_ptr][7:0];
    assign oBreak    = empty ? 1'b0  : mem[rd_ptr][8];
    assign oExtended = empty ? 1'b0  : mem[rd_ptr][9];
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx
//   Directed bench for ps2_keyboard_rx: framing, prefix decode, error flags,
//   glitch filter, watchdog, FIFO full/overflow behaviour and mid-frame reset.
module tb_ps2_keyboard_rx;
    localparam int FILTER_LEN  = 4;
    localparam int FIFO_DEPTH  = 16;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF        = 10;   // PS/2 half bit period in system clocks

    logic       Clock = 1'b0;
    logic       Reset;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic       iPop;
    logic       iClearErr;
    logic       oValid;
    logic [7:0] oCode;
    logic       oBreak;
    logic       oExtended;
    logic       oFull;
    logic       oOverflow;
    logic       oParityErr;
    logic       oFrameErr;

    int tests_run = 0;
    int tests_failed = 0;

    ps2_keyboard_rx #(
        .FILTER_LEN   (FILTER_LEN),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .TIMEOUT_CYC  (TIMEOUT_CYC),
        .DECODE_PREFIX(1'b1)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .iPop      (iPop),
        .iClearErr (iClearErr),
        .oValid    (oValid),
        .oCode     (oCode),
        .oBreak    (oBreak),
        .oExtended (oExtended),
        .oFull     (oFull),
        .oOverflow (oOverflow),
        .oParityErr(oParityErr),
        .oFrameErr (oFrameErr)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [7:0] code,
                              input logic ext, input logic brk);
        check({tag, "_valid"}, {31'd0, oValid}, 32'd1);
        check({tag, "_code"}, {24'd0, oCode}, {24'd0, code});
        check({tag, "_ext"}, {31'd0, oExtended}, {31'd0, ext});
        check({tag, "_brk"}, {31'd0, oBreak}, {31'd0, brk});
    endtask

    task automatic check_flags(input string tag, input logic ovf, input logic par, input logic frm);
        check({tag, "_ovf"}, {31'd0, oOverflow}, {31'd0, ovf});
        check({tag, "_par"}, {31'd0, oParityErr}, {31'd0, par});
        check({tag, "_frm"}, {31'd0, oFrameErr}, {31'd0, frm});
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        iPop = 1'b0;
        iClearErr = 1'b0;
        repeat (5) @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    task automatic pop();
        @(negedge Clock);
        iPop = 1'b1;
        @(negedge Clock);
        iPop = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge Clock);
        iClearErr = 1'b1;
        @(negedge Clock);
        iClearErr = 1'b0;
    endtask

    // Sends the first nbits of an 11-bit frame. The stop-bit low phase can
    // check the two-cycle write latency or pulse iPop on the write cycle:
    // raw falling edge -> 2 sync + FILTER_LEN filter -> strobe, then +2.
    task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop_b,
                              input int nbits, input logic lat_chk, input logic pop_wr);
        logic [10:0] f;
        f = {stop_b, (~(^b)) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge Clock);
            PS2_DATA = f[i];
            repeat (HALF) @(negedge Clock);
            PS2_CLK = 1'b0;
            if (i == 10 && lat_chk) begin
                repeat (2 + FILTER_LEN + 1) @(negedge Clock);
                check("latency_before", {31'd0, oValid}, 32'd0);
                @(negedge Clock);
                check("latency_at", {31'd0, oValid}, 32'd1);
                repeat (HALF - (2 + FILTER_LEN + 2)) @(negedge Clock);
            end else if (i == 10 && pop_wr) begin
                repeat (2 + FILTER_LEN + 1) @(negedge Clock);
                iPop = 1'b1;
                @(negedge Clock);
                iPop = 1'b0;
                repeat (HALF - (2 + FILTER_LEN + 2)) @(negedge Clock);
            end else begin
                repeat (HALF) @(negedge Clock);
            end
            PS2_CLK = 1'b1;
        end
        @(negedge Clock);
        PS2_DATA = 1'b1;
        repeat (HALF) @(negedge Clock);
    endtask

    task automatic frame(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        iPop = 1'b0;
        iClearErr = 1'b0;

        // 1. reset state, single frame with latency check
        do_reset();
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_code", {24'd0, oCode}, 32'd0);
        check("rst_full", {31'd0, oFull}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b1, 1'b0);
        check_head("t1", 8'h1C, 1'b0, 1'b0);
        pop();
        check("t1_empty", {31'd0, oValid}, 32'd0);

        // 2. prefix decode
        frame(8'hF0);
        check("t2_f0_not_pushed", {31'd0, oValid}, 32'd0);
        frame(8'h1C);
        frame(8'hE0);
        frame(8'hF0);
        frame(8'h75);
        check_head("t2_a", 8'h1C, 1'b0, 1'b1);
        pop();
        check_head("t2_b", 8'h75, 1'b1, 1'b1);
        pop();
        check("t2_empty", {31'd0, oValid}, 32'd0);

        // 3. parity and stop errors
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        check("t3_par_noentry", {31'd0, oValid}, 32'd0);
        check_flags("t3_par", 1'b0, 1'b1, 1'b0);
        clear_err();
        check_flags("t3_clr", 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        check("t3_stop_noentry", {31'd0, oValid}, 32'd0);
        check_flags("t3_stop", 1'b0, 1'b0, 1'b1);
        clear_err();

        // 4. short glitches with data low must not start a frame
        @(negedge Clock);
        PS2_DATA = 1'b0;
        repeat (3) begin
            repeat (HALF) @(negedge Clock);
            PS2_CLK = 1'b0;
            repeat (FILTER_LEN - 1) @(negedge Clock);
            PS2_CLK = 1'b1;
        end
        repeat (HALF) @(negedge Clock);
        PS2_DATA = 1'b1;
        repeat (TIMEOUT_CYC + 100) @(negedge Clock);
        check("t4_glitch_noentry", {31'd0, oValid}, 32'd0);
        check_flags("t4_glitch", 1'b0, 1'b0, 1'b0);
        // watchdog: clocks stop after start + 4 data bits
        send_frame(8'h3A, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        check("t4_wd_pending", {31'd0, oFrameErr}, 32'd0);
        repeat (TIMEOUT_CYC + 50) @(negedge Clock);
        check("t4_wd_frm", {31'd0, oFrameErr}, 32'd1);
        check("t4_wd_noentry", {31'd0, oValid}, 32'd0);
        clear_err();
        frame(8'h2B);
        check_head("t4_clean", 8'h2B, 1'b0, 1'b0);
        check("t4_clean_frm", {31'd0, oFrameErr}, 32'd0);
        pop();

        // 5. fill past capacity, then pop coincident with a push while full
        for (int i = 1; i <= FIFO_DEPTH + 1; i++) frame(8'(i));
        check("t5_full", {31'd0, oFull}, 32'd1);
        check("t5_ovf", {31'd0, oOverflow}, 32'd1);
        check_head("t5_head", 8'h01, 1'b0, 1'b0);
        clear_err();
        check("t5_ovf_clr", {31'd0, oOverflow}, 32'd0);
        send_frame(8'h12, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        check("t5_pp_full", {31'd0, oFull}, 32'd1);
        check("t5_pp_ovf", {31'd0, oOverflow}, 32'd0);
        check_head("t5_pp_head", 8'h02, 1'b0, 1'b0);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            check("t5_drain_code", {24'd0, oCode}, (i < FIFO_DEPTH - 1) ? i + 2 : 32'h12);
            pop();
            check("t5_drain_notfull", {31'd0, oFull}, 32'd0);
        end
        check("t5_empty", {31'd0, oValid}, 32'd0);

        // 6. mid-frame reset clears entries, pending prefix and partial frame
        frame(8'h33);
        frame(8'hF0);
        send_frame(8'h5A, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        check("t6_pre_valid", {31'd0, oValid}, 32'd1);
        do_reset();
        check("t6_rst_valid", {31'd0, oValid}, 32'd0);
        check("t6_rst_code", {24'd0, oCode}, 32'd0);
        check_flags("t6_rst", 1'b0, 1'b0, 1'b0);
        frame(8'h5A);
        check_head("t6_frame", 8'h5A, 1'b0, 1'b0);
        check_flags("t6_after", 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
